// File: rtl/fft_reorder.sv
// Reorders bit-reversed FFT frames into natural order using two ping-pong banks.
// Define FFT_REORDER_SOF_EN to add the odata_sof start-of-frame output.
module fft_reorder #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idata_en,
    input  logic [WIDTH-1:0] idata_r,
    input  logic [WIDTH-1:0] idata_i,
    output logic             odata_en,
    output logic [WIDTH-1:0] odata_r,
    output logic [WIDTH-1:0] odata_i
`ifdef FFT_REORDER_SOF_EN
    ,
    output logic             odata_sof
`endif
);

    localparam int unsigned N  = 1 << LOG2N;
    localparam int unsigned DW = 2 * WIDTH;

    typedef enum logic {IDLE, READ} state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) r[b] = a[LOG2N-1-b];
        return r;
    endfunction

    logic [DW-1:0]    mem0 [N];
    logic [DW-1:0]    mem1 [N];
    logic [LOG2N-1:0] wcnt;
    logic             wsel;
    logic [1:0]       full;
    logic             wrap_c;

    state_t           state, state_nxt;
    logic             rsel, rsel_nxt;
    logic [LOG2N-1:0] rcnt, rcnt_nxt;
    logic             clr_full_c;
    logic [LOG2N-1:0] raddr_c;
    logic [DW-1:0]    rd_word_c;

    assign wrap_c = idata_en && (&wcnt);

    // Write pointer and bank select
    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt <= '0;
            wsel <= 1'b0;
        end else if (idata_en) begin
            wcnt <= wcnt + LOG2N'(1);
            if (&wcnt) wsel <= ~wsel;
        end
    end

    // Sample storage, no reset needed
    always_ff @(posedge clock) begin
        if (idata_en && !reset) begin
            if (wsel) mem1[wcnt] <= {idata_r, idata_i};
            else      mem0[wcnt] <= {idata_r, idata_i};
        end
    end

    // Full flags: set by the writer on wrap, cleared by the reader when done
    always_ff @(posedge clock) begin
        if (reset) begin
            full <= '0;
        end else begin
            if (clr_full_c) full[rsel] <= 1'b0;
            if (wrap_c)     full[wsel] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            rsel  <= 1'b0;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            rsel  <= rsel_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    // Read sequencing: oldest full bank first, chain straight into the other bank
    always_comb begin
        state_nxt  = state;
        rsel_nxt   = rsel;
        rcnt_nxt   = rcnt;
        clr_full_c = 1'b0;
        case (state)
            IDLE: begin
                rcnt_nxt = '0;
                if (full[rsel]) begin
                    state_nxt = READ;
                end else if (full[~rsel]) begin
                    state_nxt = READ;
                    rsel_nxt  = ~rsel;
                end
            end
            READ: begin
                rcnt_nxt = rcnt + LOG2N'(1);
                if (&rcnt) begin
                    clr_full_c = 1'b1;
                    rsel_nxt   = ~rsel;
                    rcnt_nxt   = '0;
                    state_nxt  = full[~rsel] ? READ : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign raddr_c   = bitrev(rcnt);
    assign rd_word_c = rsel ? mem1[raddr_c] : mem0[raddr_c];

    // Registered outputs, forced to zero whenever not valid
    always_ff @(posedge clock) begin
        if (reset || state != READ) begin
            odata_en <= 1'b0;
            odata_r  <= '0;
            odata_i  <= '0;
        end else begin
            odata_en <= 1'b1;
            odata_r  <= rd_word_c[DW-1:WIDTH];
            odata_i  <= rd_word_c[WIDTH-1:0];
        end
    end

`ifdef FFT_REORDER_SOF_EN
    always_ff @(posedge clock) begin
        if (reset || state != READ) odata_sof <= 1'b0;
        else                        odata_sof <= (rcnt == '0);
    end
`endif

endmodule

// File: tb/tb_fft_reorder.sv
// Self-checking bench for fft_reorder: table of frame tests plus reset sequences.
// Honours FFT_REORDER_SOF_EN to also check odata_sof.
module tb_fft_reorder;

    logic        clock = 1'b0;
    logic        reset;
    logic        idata_en;
    logic [15:0] idata_r, idata_i;
    logic        odata_en;
    logic [15:0] odata_r, odata_i;
`ifdef FFT_REORDER_SOF_EN
    logic        odata_sof;
`endif

    fft_reorder #(.WIDTH(16), .LOG2N(6)) dut (
        .clock    (clock),
        .reset    (reset),
        .idata_en (idata_en),
        .idata_r  (idata_r),
        .idata_i  (idata_i),
        .odata_en (odata_en),
        .odata_r  (odata_r),
        .odata_i  (odata_i)
`ifdef FFT_REORDER_SOF_EN
        ,
        .odata_sof(odata_sof)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] r;
        logic [15:0] i;
        int          due;
        int          pos;
    } exp_t;

    typedef struct {
        int          kind;      // 0 impulse, 1 ramp
        bit          gap;
        int          frames;
        int          exp_out;
        int          spot_k;
        logic [15:0] spot_r;
        logic [15:0] spot_i;
    } vec_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          out_cnt = 0;
    int          sof_cnt = 0;
    logic [15:0] obs_r [64];
    logic [15:0] obs_i [64];
    vec_t        tbl [4];

    function automatic int br6(input int n);
        int r = 0;
        for (int b = 0; b < 6; b++) if (n[b]) r = r | (1 << (5 - b));
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Output monitor: every valid output is matched against the scoreboard, including its cycle
    always @(negedge clock) begin
        exp_t e;
        if (odata_en === 1'b1) begin
            out_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("data_r", 32'(odata_r), 32'(e.r));
                chk("data_i", 32'(odata_i), 32'(e.i));
                chk("out_cycle", 32'(cyc), 32'(e.due));
`ifdef FFT_REORDER_SOF_EN
                chk("sof", 32'(odata_sof), 32'(e.pos == 0));
`endif
                obs_r[e.pos] = odata_r;
                obs_i[e.pos] = odata_i;
            end
        end else begin
            chk("idle_zero", {odata_r, odata_i}, 32'd0);
`ifdef FFT_REORDER_SOF_EN
            chk("idle_sof", 32'(odata_sof), 32'd0);
`endif
        end
`ifdef FFT_REORDER_SOF_EN
        if (odata_sof === 1'b1) sof_cnt++;
`endif
    end

    function automatic logic [15:0] samp_r(input int kind, input int n);
        if (kind == 0) return (n == 1) ? 16'h1234 : 16'h0000;
        return 16'(n);
    endfunction

    function automatic logic [15:0] samp_i(input int kind, input int n);
        if (kind == 0) return (n == 1) ? 16'h5678 : 16'h0000;
        return 16'hFFFF - 16'(n);
    endfunction

    // Drive one frame; bin k of the output is due 2 edges after the last accept plus k
    task automatic send_frame(input int kind, input bit gap);
        exp_t e;
        for (int n = 0; n < 64; n++) begin
            @(negedge clock);
            idata_en = 1'b1;
            idata_r  = samp_r(kind, n);
            idata_i  = samp_i(kind, n);
            if (n == 63) begin
                for (int k = 0; k < 64; k++) begin
                    e.r   = samp_r(kind, br6(k));
                    e.i   = samp_i(kind, br6(k));
                    e.due = cyc + 3 + k;
                    e.pos = k;
                    q.push_back(e);
                end
            end else if (gap) begin
                @(negedge clock);
                idata_en = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        @(negedge clock);
        idata_en = 1'b0;
        while (q.size() != 0 && t < 300) begin
            @(negedge clock);
            t++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
        repeat (5) @(negedge clock);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{kind: 0, gap: 1'b0, frames: 1, exp_out: 64,  spot_k: 32, spot_r: 16'h1234, spot_i: 16'h5678};
        tbl[1] = '{kind: 1, gap: 1'b0, frames: 1, exp_out: 64,  spot_k: 1,  spot_r: 16'h0020, spot_i: 16'hFFDF};
        tbl[2] = '{kind: 1, gap: 1'b1, frames: 1, exp_out: 64,  spot_k: 6,  spot_r: 16'h0018, spot_i: 16'hFFE7};
        tbl[3] = '{kind: 1, gap: 1'b0, frames: 3, exp_out: 192, spot_k: 63, spot_r: 16'h003F, spot_i: 16'hFFC0};

        reset    = 1'b1;
        idata_en = 1'b0;
        idata_r  = '0;
        idata_i  = '0;
        repeat (3) @(negedge clock);
        chk("reset_en", 32'(odata_en), 32'd0);
        chk("reset_data", {odata_r, odata_i}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        for (int t = 0; t < 4; t++) begin
            out_cnt = 0;
            sof_cnt = 0;
            for (int f = 0; f < tbl[t].frames; f++) send_frame(tbl[t].kind, tbl[t].gap);
            drain();
            chk("out_count", 32'(out_cnt), 32'(tbl[t].exp_out));
            chk("spot_r", 32'(obs_r[tbl[t].spot_k]), 32'(tbl[t].spot_r));
            chk("spot_i", 32'(obs_i[tbl[t].spot_k]), 32'(tbl[t].spot_i));
`ifdef FFT_REORDER_SOF_EN
            chk("sof_count", 32'(sof_cnt), 32'(tbl[t].frames));
`endif
        end

        // Reset after 30 samples; idata_en held high through the reset edge must be ignored
        for (int n = 0; n < 30; n++) begin
            @(negedge clock);
            idata_en = 1'b1;
            idata_r  = 16'(n + 7);
            idata_i  = 16'hAAAA;
        end
        @(negedge clock);
        reset   = 1'b1;
        idata_r = 16'hDEAD;
        idata_i = 16'hBEEF;
        @(negedge clock);
        chk("en_in_reset", 32'(odata_en), 32'd0);
        reset    = 1'b0;
        idata_en = 1'b0;
        out_cnt  = 0;
        send_frame(0, 1'b0);
        drain();
        chk("post_reset_count", 32'(out_cnt), 32'd64);
        chk("post_reset_bin32", {obs_r[32], obs_i[32]}, 32'h12345678);
        chk("post_reset_bin0", {obs_r[0], obs_i[0]}, 32'd0);

        // Reset during readout discards the rest of the pending frame
        send_frame(1, 1'b0);
        @(negedge clock);
        idata_en = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        q.delete();
        @(negedge clock);
        chk("en_mid_read_reset", 32'(odata_en), 32'd0);
        reset   = 1'b0;
        out_cnt = 0;
        repeat (80) @(negedge clock);
        chk("no_output_after_reset", 32'(out_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_reorder.md
FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the bit width of each real and imaginary sample.
REQ-002 The block SHALL have parameter LOG2N, default 6, the log2 of the frame length N (N = 64 by default).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all logic is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port idata_en, input, 1 bit: input sample valid.
REQ-006 The block SHALL have port idata_r, input, WIDTH bits: input real part, bit-reversed frame order.
REQ-007 The block SHALL have port idata_i, input, WIDTH bits: input imaginary part, bit-reversed frame order.
REQ-008 The block SHALL have port odata_en, output, 1 bit: output sample valid.
REQ-009 The block SHALL have port odata_r, output, WIDTH bits: output real part, natural order.
REQ-010 The block SHALL have port odata_i, output, WIDTH bits: output imaginary part, natural order.

Function
REQ-011 The block SHALL accept one sample on every rising edge where idata_en=1, with no backpressure; gaps in idata_en are allowed anywhere inside a frame.
REQ-012 The block SHALL treat accepted samples 0..N-1 as one frame, where sample n holds bin bitrev(n) (LOG2N-bit reversal).
REQ-013 The block SHALL store frames in two ping-pong banks of N x (2*WIDTH) each: write counter wcnt addresses the write bank, wsel selects it, and wsel toggles and the bank's full flag is set when wcnt wraps from N-1 to 0.
REQ-014 The read side SHALL be a two-state FSM: IDLE moves to READ on the edge after any bank is full (oldest bank first); READ issues read addresses bitrev(k) for k=0..N-1 on consecutive edges.
REQ-015 After issuing k=N-1, the FSM SHALL clear that bank's full flag and then either enter READ on the other bank on the next edge (if it is full) or return to IDLE.
REQ-016 Latency SHALL be as follows: if the edge accepting sample N-1 is E0, then odata_en=1 with bin 0 at edge E0+2, and bins 1..N-1 follow on consecutive edges with no gaps.
REQ-017 Back-to-back frames at one sample per clock SHALL produce continuous odata_en with no lost or duplicated samples.
REQ-018 A write into a bank that is still being read SHALL only touch addresses already read; at input rate ≤1 sample/clock this is guaranteed by construction and needs no check.
REQ-019 odata_r and odata_i SHALL be registered, and SHALL be 0 whenever odata_en=0.
REQ-020 A simultaneous bank-full event and read completion on the same edge SHALL be handled without losing a frame (REQ-015 takes effect on that edge).

Reset
REQ-021 On any edge with reset=1, the block SHALL set wcnt=0, wsel=0, both full flags=0, FSM=IDLE, odata_en=0, odata_r=0 and odata_i=0, and SHALL ignore idata_en on that edge.
REQ-022 Reset asserted mid-frame or mid-readout SHALL discard all partial and pending data; the next accepted sample is sample 0 of a new frame.
REQ-023 Memory contents SHALL NOT require reset.

Configuration
REQ-024 When the macro FFT_REORDER_SOF_EN is defined, the block SHALL add output port odata_sof (1 bit), which is 1 exactly on the cycle bin 0 is output and 0 otherwise, with reset value 0.
REQ-025 When FFT_REORDER_SOF_EN is not defined, odata_sof SHALL be absent and all other behaviour SHALL be identical to the defined case.

Verification
REQ-026 Impulse: a frame with sample 1 = (0x1234, 0x5678) and all other samples 0 SHALL produce bin 32 = (0x1234, 0x5678) and all other bins 0.
REQ-027 Ramp: sample n = (n, 0xFFFF-n) SHALL produce bin k = (bitrev(k), 0xFFFF-bitrev(k)), with odata_en high for exactly 64 cycles starting 2 edges after the last input.
REQ-028 Three back-to-back ramp frames with idata_en continuous for 192 cycles SHALL produce odata_en continuous for 192 cycles, each 64-cycle frame correct.
REQ-029 A ramp frame with idata_en toggling 1/0 every cycle SHALL produce output identical to REQ-027, with bin 0 output 2 edges after the 64th accepted sample.
REQ-030 Reset asserted after 30 samples, followed by a full impulse frame, SHALL produce exactly 64 outputs, all matching REQ-026, and odata_en=0 during reset.
REQ-031 With FFT_REORDER_SOF_EN defined, across the REQ-028 run, odata_sof SHALL pulse exactly 3 times, each coincident with bin 0.
